acquisition_scheduler: RTL and testbench

Sequences the single acquisition controller across the satellite PRN space and hands acquired satellites to free tracking channels. Round-robin over PRNs not currently tracked: selects a PRN, lets the C/A generator settle, pulses start_acquisition, waits for acquisition_complete, and compares peak_i2q2 against a programmable threshold. On success it claims the lowest-index free tracking channel and broadcasts PRN, Doppler and code shift to it. It sits between the top-level channel bank and acquisition_controller.

---
 rtl/acquisition_scheduler_pkg.sv | 24 ++
 rtl/free_channel_select.sv | 23 ++
 rtl/acquisition_scheduler.sv | 173 +++++++++++++++++
 tb/tb_acquisition_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acquisition_scheduler_pkg.sv
// Shared widths, state encoding and acquisition result payload for the acquisition scheduler.
package acquisition_scheduler_pkg;

    localparam int unsigned I2Q2_WIDTH        = 32;
    localparam int unsigned DOPPLER_INC_WIDTH = 16;
    localparam int unsigned CS_WIDTH          = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_SETTLE = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_EVAL   = 3'd5,
        ST_ASSIGN = 3'd6
    } asch_state_e;

    typedef struct packed {
        logic [I2Q2_WIDTH-1:0]        i2q2;
        logic [DOPPLER_INC_WIDTH-1:0] doppler;
        logic [CS_WIDTH-1:0]          code_shift;
    } acq_result_t;

endpackage

// File: rtl/free_channel_select.sv
// Lowest-index free tracking channel: priority encoder over the busy vector.
module free_channel_select #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned IDX_WIDTH    = 2
) (
    input  logic [NUM_CHANNELS-1:0] chan_busy,
    output logic [IDX_WIDTH-1:0]    free_idx_c,
    output logic                    any_free_c
);

    // Scan high to low so the lowest free index is the last one written.
    always_comb begin
        free_idx_c = '0;
        any_free_c = 1'b0;
        for (int i = int'(NUM_CHANNELS) - 1; i >= 0; i--) begin
            if (!chan_busy[i]) begin
                free_idx_c = IDX_WIDTH'(i);
                any_free_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acquisition_scheduler.sv
// Round-robin PRN search sequencer: drives the acquisition controller and hands
// detections to the lowest free tracking channel.
module acquisition_scheduler
    import acquisition_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned NUM_PRNS      = 32,
    parameter int unsigned PRN_WIDTH     = 6,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         global_reset,
    input  logic                         scheduler_enable,
    input  logic [I2Q2_WIDTH-1:0]        acq_threshold,
    output logic [PRN_WIDTH-1:0]         acq_prn,
    output logic                         start_acquisition,
    input  logic                         acquisition_complete,
    input  logic [I2Q2_WIDTH-1:0]        peak_i2q2,
    input  logic [DOPPLER_INC_WIDTH-1:0] peak_doppler,
    input  logic [CS_WIDTH-1:0]          peak_code_shift,
    input  logic [NUM_CHANNELS-1:0]      chan_release,
    output logic [NUM_CHANNELS-1:0]      chan_start,
    output logic [PRN_WIDTH-1:0]         chan_prn,
    output logic [DOPPLER_INC_WIDTH-1:0] chan_doppler,
    output logic [CS_WIDTH-1:0]          chan_code_shift,
    output logic [NUM_CHANNELS-1:0]      chan_busy,
    output logic [NUM_PRNS-1:0]          tracked_mask,
    output logic                         busy
);

    localparam int unsigned IDX_WIDTH = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned CNT_WIDTH = $clog2(SETTLE_CYCLES + 1);

    asch_state_e            state;
    logic [PRN_WIDTH-1:0]   scan_ptr;
    logic [CNT_WIDTH-1:0]   settle_cnt;
    acq_result_t            result;
    logic [PRN_WIDTH-1:0]   prn_reg [NUM_CHANNELS];

    logic [IDX_WIDTH-1:0]    free_idx;
    logic                    any_free;
    logic [NUM_CHANNELS-1:0] rel_valid;
    logic [NUM_CHANNELS-1:0] set_chan;
    logic [NUM_PRNS-1:0]     clr_mask;
    logic [NUM_PRNS-1:0]     set_prn;
    logic                    do_assign;
    logic                    ptr_tracked;
    logic                    stop;

    function automatic logic [PRN_WIDTH-1:0] wrap_inc(input logic [PRN_WIDTH-1:0] p);
        return (p == PRN_WIDTH'(NUM_PRNS)) ? PRN_WIDTH'(1) : p + PRN_WIDTH'(1);
    endfunction

    function automatic logic [NUM_PRNS-1:0] prn_bit(input logic [PRN_WIDTH-1:0] p);
        return NUM_PRNS'(1) << (p - PRN_WIDTH'(1));
    endfunction

    free_channel_select #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .IDX_WIDTH    (IDX_WIDTH)
    ) u_free_channel_select (
        .chan_busy  (chan_busy),
        .free_idx_c (free_idx),
        .any_free_c (any_free)
    );

    // Occupancy bookkeeping: releases clear, assignment sets (set wins on overlap).
    always_comb begin
        rel_valid = chan_release & chan_busy;
        clr_mask  = '0;
        for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
            if (rel_valid[k]) begin
                clr_mask = clr_mask | prn_bit(prn_reg[k]);
            end
        end
        do_assign   = (state == ST_ASSIGN) && any_free;
        set_chan    = do_assign ? (NUM_CHANNELS'(1) << free_idx) : '0;
        set_prn     = do_assign ? prn_bit(acq_prn) : '0;
        ptr_tracked = |(tracked_mask & prn_bit(scan_ptr));
        stop        = !scheduler_enable || (&chan_busy) || (&tracked_mask);
    end

    always_ff @(posedge clk) begin
        if (global_reset) begin
            state             <= ST_IDLE;
            busy              <= 1'b0;
            acq_prn           <= PRN_WIDTH'(1);
            scan_ptr          <= PRN_WIDTH'(1);
            settle_cnt        <= '0;
            start_acquisition <= 1'b0;
            chan_start        <= '0;
            chan_prn          <= '0;
            chan_doppler      <= '0;
            chan_code_shift   <= '0;
            chan_busy         <= '0;
            tracked_mask      <= '0;
            result            <= '0;
            for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
                prn_reg[k] <= '0;
            end
        end else begin
            start_acquisition <= 1'b0;
            chan_start        <= '0;
            chan_busy         <= (chan_busy & ~rel_valid) | set_chan;
            tracked_mask      <= (tracked_mask & ~clr_mask) | set_prn;

            case (state)
                ST_IDLE: begin
                    if (scheduler_enable && !(&chan_busy) && !(&tracked_mask)) begin
                        state <= ST_SELECT;
                        busy  <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (!ptr_tracked) begin
                        acq_prn    <= scan_ptr;
                        settle_cnt <= CNT_WIDTH'(SETTLE_CYCLES);
                        state      <= ST_SETTLE;
                    end else begin
                        scan_ptr <= wrap_inc(scan_ptr);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt > CNT_WIDTH'(1)) begin
                        settle_cnt <= settle_cnt - CNT_WIDTH'(1);
                    end else begin
                        settle_cnt <= '0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    start_acquisition <= 1'b1;
                    state             <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (acquisition_complete) begin
                        result.i2q2       <= peak_i2q2;
                        result.doppler    <= peak_doppler;
                        result.code_shift <= peak_code_shift;
                        state             <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if ((result.i2q2 > acq_threshold) && any_free) begin
                        state <= ST_ASSIGN;
                    end else begin
                        scan_ptr <= wrap_inc(scan_ptr);
                        state    <= ST_SELECT;
                    end
                end
                ST_ASSIGN: begin
                    if (any_free) begin
                        chan_start        <= set_chan;
                        chan_prn          <= acq_prn;
                        chan_doppler      <= result.doppler;
                        chan_code_shift   <= result.code_shift;
                        prn_reg[free_idx] <= acq_prn;
                    end
                    scan_ptr <= wrap_inc(scan_ptr);
                    state    <= ST_SELECT;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acquisition_scheduler.sv
// Scoreboard bench for acquisition_scheduler: models channel/PRN occupancy and
// the expected search order, and acts as the acquisition controller.
module tb_acquisition_scheduler;
    import acquisition_scheduler_pkg::*;

    localparam int unsigned NCH    = 4;
    localparam int unsigned NPRN   = 32;
    localparam int unsigned PW     = 6;
    localparam int unsigned SETTLE = 4;

    logic                         clk = 1'b0;
    logic                         global_reset;
    logic                         scheduler_enable;
    logic [I2Q2_WIDTH-1:0]        acq_threshold;
    logic [PW-1:0]                acq_prn;
    logic                         start_acquisition;
    logic                         acquisition_complete;
    logic [I2Q2_WIDTH-1:0]        peak_i2q2;
    logic [DOPPLER_INC_WIDTH-1:0] peak_doppler;
    logic [CS_WIDTH-1:0]          peak_code_shift;
    logic [NCH-1:0]               chan_release;
    logic [NCH-1:0]               chan_start;
    logic [PW-1:0]                chan_prn;
    logic [DOPPLER_INC_WIDTH-1:0] chan_doppler;
    logic [CS_WIDTH-1:0]          chan_code_shift;
    logic [NCH-1:0]               chan_busy;
    logic [NPRN-1:0]              tracked_mask;
    logic                         busy;

    always #5 clk = ~clk;

    acquisition_scheduler #(
        .NUM_CHANNELS  (NCH),
        .NUM_PRNS      (NPRN),
        .PRN_WIDTH     (PW),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk                  (clk),
        .global_reset         (global_reset),
        .scheduler_enable     (scheduler_enable),
        .acq_threshold        (acq_threshold),
        .acq_prn              (acq_prn),
        .start_acquisition    (start_acquisition),
        .acquisition_complete (acquisition_complete),
        .peak_i2q2            (peak_i2q2),
        .peak_doppler         (peak_doppler),
        .peak_code_shift      (peak_code_shift),
        .chan_release         (chan_release),
        .chan_start           (chan_start),
        .chan_prn             (chan_prn),
        .chan_doppler         (chan_doppler),
        .chan_code_shift      (chan_code_shift),
        .chan_busy            (chan_busy),
        .tracked_mask         (tracked_mask),
        .busy                 (busy)
    );

    typedef struct packed {
        logic [NCH-1:0]               onehot;
        logic [PW-1:0]                prn;
        logic [DOPPLER_INC_WIDTH-1:0] dop;
        logic [CS_WIDTH-1:0]          cs;
    } asg_t;

    asg_t          asg_q[$];
    logic [PW-1:0] search_q[$];
    int            checks   = 0;
    int            failures = 0;

    logic [NCH-1:0]  m_busy;
    logic [NPRN-1:0] m_tracked;
    logic [PW-1:0]   m_prn [NCH];
    logic [PW-1:0]   m_ptr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p);
        return (p == PW'(NPRN)) ? PW'(1) : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] next_untracked();
        logic [PW-1:0] p;
        p = m_ptr;
        for (int i = 0; i < int'(NPRN); i++) begin
            if (!m_tracked[int'(p) - 1]) return p;
            p = wrap(p);
        end
        return '0;
    endfunction

    task automatic model_reset();
        m_busy    = '0;
        m_tracked = '0;
        m_ptr     = PW'(1);
        for (int c = 0; c < int'(NCH); c++) m_prn[c] = '0;
    endtask

    task automatic model_release(input logic [NCH-1:0] mask);
        for (int c = 0; c < int'(NCH); c++) begin
            if (mask[c] && m_busy[c]) begin
                m_busy[c] = 1'b0;
                m_tracked[int'(m_prn[c]) - 1] = 1'b0;
            end
        end
    endtask

    task automatic release_pulse(input logic [NCH-1:0] mask);
        chan_release = mask;
        tick();
        chan_release = '0;
        model_release(mask);
    endtask

    task automatic check_reset_values(input string pfx);
        check_eq({pfx, "_acq_prn"}, acq_prn, 1);
        check_eq({pfx, "_start_acq"}, start_acquisition, 0);
        check_eq({pfx, "_chan_start"}, chan_start, 0);
        check_eq({pfx, "_chan_prn"}, chan_prn, 0);
        check_eq({pfx, "_chan_doppler"}, chan_doppler, 0);
        check_eq({pfx, "_chan_cs"}, chan_code_shift, 0);
        check_eq({pfx, "_chan_busy"}, chan_busy, 0);
        check_eq({pfx, "_tracked"}, tracked_mask, 0);
        check_eq({pfx, "_busy"}, busy, 0);
    endtask

    // Waits for the start pulse, checks the searched PRN and the pulse width.
    task automatic wait_start(output int n, output bit seen);
        logic [PW-1:0] exp_prn;
        n = 0;
        while (start_acquisition !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        seen    = (start_acquisition === 1'b1);
        exp_prn = search_q.pop_front();
        check_eq("start_seen", start_acquisition, 1);
        if (!seen) return;
        check_eq("acq_prn", acq_prn, exp_prn);
        tick();
        check_eq("start_pulse_width", start_acquisition, 0);
    endtask

    task automatic expect_no_start(input int cycles);
        int cnt;
        cnt = 0;
        repeat (cycles) begin
            tick();
            if (start_acquisition) cnt++;
        end
        check_eq("no_start", cnt, 0);
    endtask

    task automatic do_search(input logic [I2Q2_WIDTH-1:0] peak,
                             input logic [DOPPLER_INC_WIDTH-1:0] dop,
                             input logic [CS_WIDTH-1:0] cs,
                             input logic [NCH-1:0] rel_at_assign,
                             input logic [NCH-1:0] pre_rel,
                             input bit drop_en,
                             input bit check_lat,
                             input int exp_lat);
        logic [PW-1:0]  exp_prn;
        logic [NCH-1:0] busy_old;
        int             n;
        int             k;
        bit             seen;
        bit             hit;
        exp_prn = next_untracked();
        search_q.push_back(exp_prn);
        wait_start(n, seen);
        if (!seen) return;
        if (check_lat) check_eq("start_latency", n, exp_lat);
        if (drop_en) scheduler_enable = 1'b0;
        if (pre_rel != '0) release_pulse(pre_rel);

        busy_old = m_busy;
        k = -1;
        for (int c = int'(NCH) - 1; c >= 0; c--) if (!busy_old[c]) k = c;
        hit = (peak > acq_threshold) && (k >= 0);
        peak_i2q2            = peak;
        peak_doppler         = dop;
        peak_code_shift      = cs;
        acquisition_complete = 1'b1;
        if (hit) asg_q.push_back('{onehot: NCH'(1) << k, prn: exp_prn, dop: dop, cs: cs});
        tick();
        acquisition_complete = 1'b0;
        peak_i2q2            = '0;
        peak_doppler         = '0;
        peak_code_shift      = '0;
        tick();
        chan_release = rel_at_assign;
        tick();
        chan_release = '0;

        model_release(rel_at_assign & busy_old);
        if (hit) begin
            m_busy[k] = 1'b1;
            m_tracked[int'(exp_prn) - 1] = 1'b1;
            m_prn[k] = exp_prn;
        end
        m_ptr = wrap(exp_prn);
    endtask

    // Assignment monitor: every chan_start pulse must match the oldest expected assignment.
    always @(negedge clk) begin : mon
        asg_t e;
        if (!global_reset && chan_start != '0) begin
            if (asg_q.size() == 0) begin
                check_eq("unexpected_chan_start", chan_start, 0);
            end else begin
                e = asg_q.pop_front();
                check_eq("chan_start", chan_start, e.onehot);
                check_eq("chan_prn", chan_prn, e.prn);
                check_eq("chan_doppler", chan_doppler, e.dop);
                check_eq("chan_code_shift", chan_code_shift, e.cs);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        global_reset         = 1'b1;
        scheduler_enable     = 1'b0;
        acq_threshold        = 100;
        acquisition_complete = 1'b0;
        peak_i2q2            = '0;
        peak_doppler         = '0;
        peak_code_shift      = '0;
        chan_release         = '0;
        model_reset();
        repeat (3) tick();
        check_reset_values("reset");
        global_reset = 1'b0;
        tick();
        check_eq("idle_when_disabled", busy, 0);

        // Full sweep of misses: PRN 1..32 then wrap to 1.
        scheduler_enable = 1'b1;
        for (int i = 0; i < 33; i++) begin
            do_search(50, '0, '0, '0, '0, 1'b0, 1'b1, (i == 0) ? 7 : 5);
        end
        check_eq("sweep_no_busy", chan_busy, 0);

        // PRN 2 miss, PRN 3 detection into channel 0.
        do_search(50, '0, '0, '0, '0, 1'b0, 1'b1, 5);
        do_search(200, 16'h01F4, 11'h155, '0, '0, 1'b0, 1'b1, 5);
        check_eq("hit_chan_busy", chan_busy, 4'b0001);
        check_eq("hit_tracked", tracked_mask, 32'h0000_0004);

        // PRN 4: peak equal to threshold is a miss.
        do_search(100, 16'h0777, 11'h077, '0, '0, 1'b0, 1'b1, 6);
        check_eq("equal_no_assign", chan_busy, 4'b0001);

        // Fill remaining channels with PRNs 5, 6, 7.
        do_search(300, 16'h1005, 11'h005, '0, '0, 1'b0, 1'b1, 5);
        do_search(310, 16'h1006, 11'h006, '0, '0, 1'b0, 1'b0, 0);
        do_search(320, 16'h1007, 11'h007, '0, '0, 1'b0, 1'b0, 0);
        expect_no_start(20);
        check_eq("full_idle", busy, 0);
        check_eq("full_chan_busy", chan_busy, 4'b1111);
        check_eq("full_tracked", tracked_mask, m_tracked);

        // Release channel 2; the next hit (PRN 8) reuses it.
        release_pulse(4'b0100);
        do_search(250, 16'h0123, 11'h0AA, '0, '0, 1'b0, 1'b0, 0);
        check_eq("reuse_chan_busy", chan_busy, 4'b1111);

        // Release on channel 0 in the ASSIGN cycle: channel 3 is the one assigned.
        release_pulse(4'b1000);
        check_eq("rel3_chan_busy", chan_busy, 4'b0111);
        do_search(400, 16'hBEEF, 11'h3FF, 4'b0001, '0, 1'b0, 1'b0, 0);
        check_eq("rel_assign_chan_busy", chan_busy, 4'b1110);
        check_eq("rel_assign_tracked", tracked_mask, m_tracked);

        // Double release during WAIT, enable dropped mid-search: PRN 10 still assigned.
        do_search(500, 16'h0A0A, 11'h10A, '0, 4'b0110, 1'b1, 1'b0, 0);
        expect_no_start(20);
        check_eq("drop_en_idle", busy, 0);
        check_eq("drop_en_chan_busy", chan_busy, 4'b1001);
        check_eq("drop_en_tracked", tracked_mask, m_tracked);

        // Reset while waiting on PRN 11.
        scheduler_enable = 1'b1;
        search_q.push_back(next_untracked());
        wait_start(n, seen);
        check_eq("pre_reset_busy", busy, 1);
        scheduler_enable = 1'b0;
        global_reset     = 1'b1;
        tick();
        check_reset_values("midwait_reset");
        global_reset = 1'b0;
        model_reset();
        tick();
        check_eq("assign_queue_drained", asg_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
